// File: rtl/impulse_noise_gen_pkg.sv
// Shared constants and types for the impulse noise generator: LFSR taps,
// default seed, FSM state encoding and the LFSR field decode used per sample.
package noise_pkg;

  localparam int          DATA_W       = 8;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic       pol;
    logic [1:0] len_m1;
    logic [7:0] thresh;
  } lfsr_fields_t;

  // Bits 15:11 of the LFSR are intentionally not consulted by the decision logic.
  function automatic lfsr_fields_t lfsr_fields(input logic [15:0] l);
    lfsr_fields_t f;
    f.pol    = l[8];
    f.len_m1 = l[10:9];
    f.thresh = l[7:0];
    return f;
  endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit right-shifting Galois LFSR with step enable and synchronous seed load.
module lfsr16_galois
  import noise_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (load_i) begin
      lfsr_q <= SEED;
    end else if (step_i) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/impulse_noise_gen.sv
// Single-stage registered pipeline that replaces bursts of samples with 0x00/0xFF
// impulses, driven by a Galois LFSR, and counts corrupted samples.
module impulse_noise_gen
  import noise_pkg::*;
#(
  parameter logic [15:0] SEED      = DEFAULT_SEED,
  parameter int          BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              enable,
  input  logic [7:0]        rate,
  input  logic              hit_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_hit,
  output logic [15:0]       hit_count
);

  localparam logic [2:0] BURST_CAP = 3'(BURST_MAX);

  state_e            state_q, state_d;
  logic [1:0]        rem_q, rem_d;
  logic              pol_q, pol_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q, data_d;
  logic              out_hit_q, hit_d;
  logic [15:0]       hit_count_q;
  logic [15:0]       lfsr_val;
  lfsr_fields_t      fld;
  logic              accept;
  logic [2:0]        len_raw, len_cap;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  lfsr16_galois #(
    .SEED (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (1'b0),
    .step_i  (accept && enable),
    .state_o (lfsr_val)
  );

  // Decision uses the LFSR value present in the accept cycle, before it steps.
  always_comb begin
    fld     = lfsr_fields(lfsr_val);
    len_raw = {1'b0, fld.len_m1} + 3'd1;
    len_cap = (len_raw > BURST_CAP) ? BURST_CAP : len_raw;
    state_d = ST_IDLE;
    rem_d   = 2'd0;
    pol_d   = pol_q;
    hit_d   = 1'b0;
    data_d  = in_data;
    if (enable) begin
      if (state_q == ST_BURST) begin
        hit_d   = 1'b1;
        data_d  = {DATA_W{pol_q}};
        rem_d   = (rem_q != 2'd0) ? rem_q - 2'd1 : 2'd0;
        state_d = (rem_d != 2'd0) ? ST_BURST : ST_IDLE;
      end else if (fld.thresh < rate) begin
        hit_d   = 1'b1;
        pol_d   = fld.pol;
        data_d  = {DATA_W{fld.pol}};
        rem_d   = 2'(len_cap - 3'd1);
        state_d = (rem_d != 2'd0) ? ST_BURST : ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= 2'd0;
      pol_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_hit_q   <= 1'b0;
      hit_count_q <= 16'h0000;
    end else begin
      if (accept) begin
        state_q     <= state_d;
        rem_q       <= rem_d;
        pol_q       <= pol_d;
        out_valid_q <= 1'b1;
        out_data_q  <= data_d;
        out_hit_q   <= hit_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (hit_clr) begin
        hit_count_q <= 16'h0000;
      end else if (accept && hit_d && (hit_count_q != 16'hFFFF)) begin
        hit_count_q <= hit_count_q + 16'h0001;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_hit   = out_hit_q;
  assign hit_count = hit_count_q;

endmodule

// File: tb/tb_impulse_noise_gen.sv
// Directed bench for impulse_noise_gen with hand-computed LFSR-driven expectations.
module tb_impulse_noise_gen;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        enable;
  logic [7:0]  rate;
  logic        hit_clr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_hit;
  logic [15:0] hit_count;

  int n_assert;
  int n_fail;

  impulse_noise_gen #(
    .SEED      (16'hACE1),
    .BURST_MAX (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .enable    (enable),
    .rate      (rate),
    .hit_clr   (hit_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_hit   (out_hit),
    .hit_count (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic [7:0] d,
                      input logic [7:0] exp_d, input logic exp_h);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, ".valid"}, 16'(out_valid), 16'h1);
    chk({tag, ".data"},  16'(out_data),  16'(exp_d));
    chk({tag, ".hit"},   16'(out_hit),   16'(exp_h));
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({tag, ".rst_valid"}, 16'(out_valid), 16'h0);
    chk({tag, ".rst_data"},  16'(out_data),  16'h0);
    chk({tag, ".rst_hit"},   16'(out_hit),   16'h0);
    chk({tag, ".rst_count"}, hit_count,      16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({tag, ".rdy_after_rst"}, 16'(in_ready), 16'h1);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    enable    = 1'b1;
    rate      = 8'd0;
    hit_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    pulse_reset("init");

    // rate=0: pure pass-through while the LFSR still steps (ACE1->E270->7138->389C->1C4E->0E27)
    send("r0_a", 8'h10, 8'h10, 1'b0);
    send("r0_b", 8'h20, 8'h20, 1'b0);
    send("r0_c", 8'h30, 8'h30, 1'b0);
    chk("r0_count", hit_count, 16'h0000);
    send("r0_d", 8'h40, 8'h40, 1'b0);

    // Backpressure: hold 0x50 at the input while the sink stalls
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h50;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 16'(out_valid), 16'h1);
      chk("stall_data",  16'(out_data),  16'h40);
      chk("stall_ready", 16'(in_ready),  16'h0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("resume_data", 16'(out_data), 16'h50);
    chk("resume_hit",  16'(out_hit),  16'h0);
    @(posedge clk);
    #1;
    chk("drain_valid", 16'(out_valid), 16'h0);

    // LFSR=0x0E27 if stall did not step it: hit, pol 0
    rate = 8'd255;
    send("post_stall", 8'hE1, 8'h00, 1'b1);
    chk("post_stall_count", hit_count, 16'h0001);

    // Burst from SEED, abandoned by reset after its first sample
    pulse_reset("rst1");
    send("b1_first", 8'h55, 8'h00, 1'b1);
    pulse_reset("rst_mid");

    // Replay from SEED: length-3 burst of 0x00 then 4th from 0x389C (hit, pol 0, length 1)
    send("b2_s1", 8'h55, 8'h00, 1'b1);
    send("b2_s2", 8'h55, 8'h00, 1'b1);
    send("b2_s3", 8'h55, 8'h00, 1'b1);
    chk("b2_count3", hit_count, 16'h0003);
    send("b2_s4", 8'h55, 8'h00, 1'b1);
    chk("b2_count4", hit_count, 16'h0004);

    // From 0x1C4E: burst length 3 starts; enable=0 abandons it and freezes LFSR at 0x0E27
    send("en_burst", 8'h5A, 8'h00, 1'b1);
    enable = 1'b0;
    send("en0_a", 8'h77, 8'h77, 1'b0);
    send("en0_b", 8'h88, 8'h88, 1'b0);
    enable = 1'b1;
    rate   = 8'd0;
    send("en1_noburst", 8'h99, 8'h99, 1'b0);
    chk("en_count", hit_count, 16'h0005);

    // From 0xB313: hit, pol 1, length 2
    rate = 8'd255;
    send("pol1_first", 8'hC3, 8'hFF, 1'b1);
    chk("pol1_count", hit_count, 16'h0006);

    // Second burst sample coincides with hit_clr: clear wins
    rate    = 8'd0;
    hit_clr = 1'b1;
    send("clr_burst", 8'h3C, 8'hFF, 1'b1);
    hit_clr = 1'b0;
    chk("clr_count", hit_count, 16'h0000);
    send("burst_done", 8'h11, 8'h11, 1'b0);
    chk("final_count", hit_count, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
